// File: rtl/bird_motion.sv
// Bird sprite motion controller: steps the bird across the screen, handles hits, death and respawn.
// Optional feature: define BIRD_MOTION_ZIGZAG_EN for an alternating +1/-1 vertical wobble on each step.
module bird_motion #(
  parameter logic [7:0] X_START     = 8'd5,
  parameter logic [7:0] X_MAX       = 8'd159,
  parameter logic [6:0] Y_MIN       = 7'd4,
  parameter logic [6:0] Y_MAX       = 7'd100,
  parameter logic [5:0] STEP_FRAMES = 6'd15,
  parameter logic [5:0] DEAD_FRAMES = 6'd30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       hit,
  input  logic       draw_done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] erase_x,
  output logic [6:0] erase_y,
  output logic       draw_req,
  output logic       alive,
  output logic       escaped
);

  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int unsigned CNTW = 6;
  localparam logic [YW-1:0] RESET_Y = 7'd7;

  typedef enum logic [1:0] {S_WAIT, S_DRAW, S_DEAD} state_t;

  state_t state_q, state_d;

  logic [XW-1:0]   x_q, x_d, erase_x_q, erase_x_d;
  logic [YW-1:0]   y_q, y_d, erase_y_q, erase_y_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            draw_req_q, draw_req_d;
  logic            alive_q, alive_d;
  logic            escaped_q, escaped_d;
  logic            dying_q, dying_d;
  logic            rerase_q, rerase_d;
`ifdef BIRD_MOTION_ZIGZAG_EN
  logic            zig_q, zig_d;
`endif

  logic [YW-1:0] spawn_y;
  logic [YW-1:0] step_y;
  logic          hit_ok;
  logic          kill;
  logic          step_due;
  logic          dead_due;
  logic          hit_draw;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; non-zero seed keeps it out of the all-zero lock-up state
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Fold the random value into the legal row band
  always_comb begin
    spawn_y = lfsr_q[6:0];
    if (spawn_y > Y_MAX) spawn_y = spawn_y - 7'd64;
    if (spawn_y < Y_MIN) spawn_y = spawn_y + Y_MIN;
    if (spawn_y > Y_MAX) spawn_y = Y_MAX;
  end

  // Row after a non-wrap step
  always_comb begin
    step_y = y_q;
`ifdef BIRD_MOTION_ZIGZAG_EN
    if (!zig_q) step_y = (y_q >= Y_MAX) ? Y_MAX : y_q + 7'd1;
    else        step_y = (y_q <= Y_MIN) ? Y_MIN : y_q - 7'd1;
`endif
  end

  // A hit only counts for a visible bird not already on its way to dying
  assign hit_ok   = hit && alive_q && !dying_q;
  assign kill     = (state_q == S_WAIT) && (hit_ok || rerase_q);
  assign step_due = (state_q == S_WAIT) && enable && frame_tick &&
                    (cnt_q == STEP_FRAMES - 6'd1);
  assign dead_due = (state_q == S_DEAD) && frame_tick && (cnt_q == DEAD_FRAMES - 6'd1);
  assign hit_draw = (state_q == S_DRAW) && hit_ok;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_WAIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT: if (kill || step_due) state_d = S_DRAW;
      S_DRAW: begin
        if (draw_done) begin
          // A hit caught during this request still owes an erase of the current sprite
          if (rerase_q || hit_draw) state_d = S_WAIT;
          else if (dying_q)         state_d = S_DEAD;
          else                      state_d = S_WAIT;
        end
      end
      S_DEAD: if (dead_due) state_d = S_DRAW;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    erase_x_d  = erase_x_q;
    erase_y_d  = erase_y_q;
    cnt_d      = cnt_q;
    draw_req_d = draw_req_q;
    alive_d    = alive_q;
    escaped_d  = 1'b0;
    dying_d    = dying_q;
    rerase_d   = rerase_q;
`ifdef BIRD_MOTION_ZIGZAG_EN
    zig_d      = zig_q;
`endif
    unique case (state_q)
      S_WAIT: begin
        if (kill) begin
          erase_x_d  = x_q;
          erase_y_d  = y_q;
          alive_d    = 1'b0;
          cnt_d      = '0;
          dying_d    = 1'b1;
          rerase_d   = 1'b0;
          draw_req_d = 1'b1;
        end else if (enable && frame_tick) begin
          if (step_due) begin
            cnt_d      = '0;
            erase_x_d  = x_q;
            erase_y_d  = y_q;
            draw_req_d = 1'b1;
            if (x_q == X_MAX) begin
              x_d       = X_START;
              y_d       = spawn_y;
              escaped_d = 1'b1;
`ifdef BIRD_MOTION_ZIGZAG_EN
              zig_d     = 1'b0;
`endif
            end else begin
              x_d = x_q + 8'd1;
              y_d = step_y;
`ifdef BIRD_MOTION_ZIGZAG_EN
              zig_d = ~zig_q;
`endif
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_DRAW: begin
        if (hit_ok) begin
          dying_d  = 1'b1;
          rerase_d = 1'b1;
        end
        if (draw_done) draw_req_d = 1'b0;
      end
      S_DEAD: begin
        if (frame_tick) begin
          if (dead_due) begin
            cnt_d      = '0;
            x_d        = X_START;
            y_d        = spawn_y;
            erase_x_d  = X_START;
            erase_y_d  = spawn_y;
            alive_d    = 1'b1;
            dying_d    = 1'b0;
            draw_req_d = 1'b1;
`ifdef BIRD_MOTION_ZIGZAG_EN
            zig_d      = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q        <= X_START;
      y_q        <= RESET_Y;
      erase_x_q  <= X_START;
      erase_y_q  <= RESET_Y;
      cnt_q      <= '0;
      lfsr_q     <= 8'hA5;
      draw_req_q <= 1'b0;
      alive_q    <= 1'b1;
      escaped_q  <= 1'b0;
      dying_q    <= 1'b0;
      rerase_q   <= 1'b0;
`ifdef BIRD_MOTION_ZIGZAG_EN
      zig_q      <= 1'b0;
`endif
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      erase_x_q  <= erase_x_d;
      erase_y_q  <= erase_y_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      draw_req_q <= draw_req_d;
      alive_q    <= alive_d;
      escaped_q  <= escaped_d;
      dying_q    <= dying_d;
      rerase_q   <= rerase_d;
`ifdef BIRD_MOTION_ZIGZAG_EN
      zig_q      <= zig_d;
`endif
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign erase_x  = erase_x_q;
  assign erase_y  = erase_y_q;
  assign draw_req = draw_req_q;
  assign alive    = alive_q;
  assign escaped  = escaped_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed self-checking bench for bird_motion: stepping, wrap, hits, death/respawn, enable and reset.
module tb_bird_motion;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic       draw_done = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [7:0] erase_x;
  logic [6:0] erase_y;
  logic       draw_req;
  logic       alive;
  logic       escaped;

  int checks = 0;
  int errors = 0;

  bird_motion dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .enable     (enable),
    .hit        (hit),
    .draw_done  (draw_done),
    .x          (x),
    .y          (y),
    .erase_x    (erase_x),
    .erase_y    (erase_y),
    .draw_req   (draw_req),
    .alive      (alive),
    .escaped    (escaped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Complete a pending draw request within a bounded number of cycles
  task automatic ack();
    int n = 0;
    while (draw_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (draw_req !== 1'b1) begin
      errors++;
      $display("FAIL ack_wait draw_req got %b want 1", draw_req);
    end
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    checks++;
    if (draw_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_release draw_req got %b want 0", draw_req);
    end
  endtask

  task automatic step();
    ticks(15);
    ack();
  endtask

  task automatic test_reset();
    frame_tick = 1'b0; enable = 1'b0; hit = 1'b0; draw_done = 1'b0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({x, y, erase_x, erase_y} !== {8'd5, 7'd7, 8'd5, 7'd7}) begin
      errors++;
      $display("FAIL reset_pos got x=%0d y=%0d ex=%0d ey=%0d want 5 7 5 7", x, y, erase_x, erase_y);
    end
    checks++;
    if ({draw_req, alive, escaped} !== 3'b010) begin
      errors++;
      $display("FAIL reset_flags got req/alive/esc=%b%b%b want 010", draw_req, alive, escaped);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_step();
    enable = 1'b1;
    ticks(14);
    checks++;
    if (x !== 8'd5 || draw_req !== 1'b0) begin
      errors++;
      $display("FAIL step_early got x=%0d req=%b want 5 0", x, draw_req);
    end
    tick();
    checks++;
    if ({x, y, erase_x, erase_y, draw_req, alive} !== {8'd6, 7'd7, 8'd5, 7'd7, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL step_first got x=%0d y=%0d ex=%0d ey=%0d req=%b alive=%b want 6 7 5 7 1 1",
               x, y, erase_x, erase_y, draw_req, alive);
    end
    ticks(3);
    checks++;
    if (x !== 8'd6 || draw_req !== 1'b1 || erase_x !== 8'd5) begin
      errors++;
      $display("FAIL draw_hold got x=%0d ex=%0d req=%b want 6 5 1", x, erase_x, draw_req);
    end
    ack();
    ticks(14);
    checks++;
    if (x !== 8'd6 || draw_req !== 1'b0) begin
      errors++;
      $display("FAIL step_cnt_clear got x=%0d req=%b want 6 0", x, draw_req);
    end
    tick();
    checks++;
    if (x !== 8'd7 || erase_x !== 8'd6) begin
      errors++;
      $display("FAIL step_second got x=%0d ex=%0d want 7 6", x, erase_x);
    end
    ack();
  endtask

  task automatic test_enable();
    enable = 1'b0;
    ticks(100);
    checks++;
    if (x !== 8'd7 || draw_req !== 1'b0) begin
      errors++;
      $display("FAIL enable_freeze got x=%0d req=%b want 7 0", x, draw_req);
    end
    enable = 1'b1;
    ticks(14);
    checks++;
    if (x !== 8'd7) begin
      errors++;
      $display("FAIL enable_resume_early got x=%0d want 7", x);
    end
    tick();
    checks++;
    if (x !== 8'd8 || draw_req !== 1'b1) begin
      errors++;
      $display("FAIL enable_resume_step got x=%0d req=%b want 8 1", x, draw_req);
    end
    ack();
  endtask

  task automatic test_zigzag();
    logic [6:0] exp_y;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef BIRD_MOTION_ZIGZAG_EN
      exp_y = (i % 2 == 0) ? 7'd8 : 7'd7;
`else
      exp_y = 7'd7;
`endif
      checks++;
      if (y !== exp_y || x !== 8'(6 + i)) begin
        errors++;
        $display("FAIL zigzag_step%0d got x=%0d y=%0d want %0d %0d", i, x, y, 6 + i, exp_y);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    while (x !== 8'd159 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (x !== 8'd159 || n != 150) begin
      errors++;
      $display("FAIL wrap_preload got x=%0d steps=%0d want 159 150", x, n);
    end
    ticks(15);
    checks++;
    if (x !== 8'd5 || erase_x !== 8'd159 || escaped !== 1'b1 || draw_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_step got x=%0d ex=%0d esc=%b req=%b want 5 159 1 1", x, erase_x, escaped, draw_req);
    end
    checks++;
    if (y < 7'd4 || y > 7'd100) begin
      errors++;
      $display("FAIL wrap_row got y=%0d want 4..100", y);
    end
    @(negedge clock);
    checks++;
    if (escaped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse got esc=%b want 0", escaped);
    end
    ack();
  endtask

  task automatic test_hit();
    repeat (15) step();
    checks++;
    if (x !== 8'd20) begin
      errors++;
      $display("FAIL hit_preload got x=%0d want 20", x);
    end
    hit = 1'b1;
    @(negedge clock);
    hit = 1'b0;
    checks++;
    if ({x, erase_x, alive, draw_req} !== {8'd20, 8'd20, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hit_wait got x=%0d ex=%0d alive=%b req=%b want 20 20 0 1", x, erase_x, alive, draw_req);
    end
    ack();
    ticks(29);
    hit = 1'b1;
    @(negedge clock);
    hit = 1'b0;
    checks++;
    if (alive !== 1'b0 || draw_req !== 1'b0 || x !== 8'd20) begin
      errors++;
      $display("FAIL dead_count got x=%0d alive=%b req=%b want 20 0 0", x, alive, draw_req);
    end
    tick();
    checks++;
    if ({x, erase_x, alive, draw_req} !== {8'd5, 8'd5, 1'b1, 1'b1} || erase_y !== y) begin
      errors++;
      $display("FAIL respawn got x=%0d ex=%0d alive=%b req=%b y=%0d ey=%0d want 5 5 1 1 ey=y",
               x, erase_x, alive, draw_req, y, erase_y);
    end
    checks++;
    if (y < 7'd4 || y > 7'd100) begin
      errors++;
      $display("FAIL respawn_row got y=%0d want 4..100", y);
    end
    ack();
  endtask

  task automatic test_hit_step_same();
    ticks(14);
    frame_tick = 1'b1;
    hit = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    hit = 1'b0;
    checks++;
    if ({x, erase_x, alive, draw_req} !== {8'd5, 8'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hit_vs_step got x=%0d ex=%0d alive=%b req=%b want 5 5 0 1", x, erase_x, alive, draw_req);
    end
    ack();
    ticks(30);
    checks++;
    if (alive !== 1'b1 || x !== 8'd5 || draw_req !== 1'b1) begin
      errors++;
      $display("FAIL hit_vs_step_respawn got x=%0d alive=%b req=%b want 5 1 1", x, alive, draw_req);
    end
    ack();
  endtask

  task automatic test_hit_in_draw();
    ticks(15);
    hit = 1'b1;
    @(negedge clock);
    hit = 1'b0;
    checks++;
    if ({x, erase_x, draw_req} !== {8'd6, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL draw_hit_hold got x=%0d ex=%0d req=%b want 6 5 1", x, erase_x, draw_req);
    end
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    checks++;
    if (draw_req !== 1'b0) begin
      errors++;
      $display("FAIL draw_hit_done got req=%b want 0", draw_req);
    end
    @(negedge clock);
    checks++;
    if ({x, erase_x, alive, draw_req} !== {8'd6, 8'd6, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL draw_hit_erase got x=%0d ex=%0d alive=%b req=%b want 6 6 0 1", x, erase_x, alive, draw_req);
    end
    ack();
    ticks(29);
    checks++;
    if (alive !== 1'b0 || draw_req !== 1'b0) begin
      errors++;
      $display("FAIL draw_hit_dead got alive=%b req=%b want 0 0", alive, draw_req);
    end
    tick();
    checks++;
    if (alive !== 1'b1 || x !== 8'd5 || draw_req !== 1'b1) begin
      errors++;
      $display("FAIL draw_hit_respawn got x=%0d alive=%b req=%b want 5 1 1", x, alive, draw_req);
    end
    ack();
  endtask

  task automatic test_reset_mid_draw();
    ticks(15);
    checks++;
    if (draw_req !== 1'b1 || x !== 8'd6) begin
      errors++;
      $display("FAIL mid_draw_setup got x=%0d req=%b want 6 1", x, draw_req);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (draw_req !== 1'b0 || x !== 8'd5 || alive !== 1'b1) begin
      errors++;
      $display("FAIL mid_draw_reset got x=%0d req=%b alive=%b want 5 0 1", x, draw_req, alive);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (draw_req !== 1'b0 || x !== 8'd5) begin
      errors++;
      $display("FAIL mid_draw_after got x=%0d req=%b want 5 0", x, draw_req);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_enable();
    test_zigzag();
    test_wrap();
    test_hit();
    test_hit_step_same();
    test_hit_in_draw();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
